// File: rtl/isram_arb2_ahbl.sv
// Two-master AHB-Lite arbiter sharing the instruction SRAM; a losing master parks in a one-deep pending buffer.
// Zero added latency when uncontended; losers and requests raised during a slave stall see hready low until served.
module isram_arb2_ahbl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [ADDR_WIDTH-1:0] m0_haddr,
  input  logic [1:0]            m0_htrans,
  input  logic                  m0_hwrite,
  input  logic [2:0]            m0_hsize,
  input  logic [DATA_WIDTH-1:0] m0_hwdata,
  output logic [DATA_WIDTH-1:0] m0_hrdata,
  output logic                  m0_hready,
  output logic                  m0_hresp,
  input  logic [ADDR_WIDTH-1:0] m1_haddr,
  input  logic [1:0]            m1_htrans,
  input  logic                  m1_hwrite,
  input  logic [2:0]            m1_hsize,
  input  logic [DATA_WIDTH-1:0] m1_hwdata,
  output logic [DATA_WIDTH-1:0] m1_hrdata,
  output logic                  m1_hready,
  output logic                  m1_hresp,
  output logic [ADDR_WIDTH-1:0] s_haddr,
  output logic [1:0]            s_htrans,
  output logic                  s_hwrite,
  output logic [2:0]            s_hsize,
  output logic [2:0]            s_hburst,
  output logic [DATA_WIDTH-1:0] s_hwdata,
  input  logic [DATA_WIDTH-1:0] s_hrdata,
  input  logic                  s_hready,
  input  logic                  s_hresp
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  write;
    logic [2:0]            size;
  } ahb_ap_t;

  typedef enum logic [1:0] {
    DP_NONE = 2'd0,
    DP_M0   = 2'd1,
    DP_M1   = 2'd2
  } dp_owner_e;

  logic      pend_v0, pend_v1;
  ahb_ap_t   pend_ap0, pend_ap1;
  dp_owner_e dp_owner;
  logic      last_grant;   // 0 = M0, 1 = M1
  logic      sel_q;
  logic      stall_q;

  logic      live0, live1;
  ahb_ap_t   live_ap0, live_ap1, sel_ap;
  logic      sel, s_vld, acc;

  // SEQ is treated like NONSEQ: every beat is re-arbitrated as a single transfer
  assign live0 = m0_hready && (m0_htrans inside {2'b10, 2'b11});
  assign live1 = m1_hready && (m1_htrans inside {2'b10, 2'b11});

  assign live_ap0 = '{addr: m0_haddr, write: m0_hwrite, size: m0_hsize};
  assign live_ap1 = '{addr: m1_haddr, write: m1_hwrite, size: m1_hsize};

  // An address phase the slave stalled must stay on the bus; it already sits in its pending buffer
  always_comb begin
    sel   = sel_q;
    s_vld = 1'b0;
    if (stall_q) begin
      s_vld = 1'b1;
    end else if (pend_v0 || pend_v1) begin
      s_vld = 1'b1;
      sel   = (pend_v0 && pend_v1) ? ~last_grant : pend_v1;
    end else if (live0 || live1) begin
      s_vld = 1'b1;
      sel   = (live0 && live1) ? ~last_grant : live1;
    end
  end

  assign sel_ap = sel ? (pend_v1 ? pend_ap1 : live_ap1) : (pend_v0 ? pend_ap0 : live_ap0);
  assign acc    = s_vld && s_hready;

  assign s_htrans = s_vld ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign s_haddr  = s_vld ? sel_ap.addr : '0;
  assign s_hwrite = s_vld && sel_ap.write;
  assign s_hsize  = s_vld ? sel_ap.size : 3'b000;
  assign s_hburst = 3'b000;

  always_comb begin
    s_hwdata = '0;
    case (dp_owner)
      DP_M0:   s_hwdata = m0_hwdata;
      DP_M1:   s_hwdata = m1_hwdata;
      default: s_hwdata = '0;
    endcase
  end

  assign m0_hready = (dp_owner == DP_M0) ? s_hready : ~pend_v0;
  assign m1_hready = (dp_owner == DP_M1) ? s_hready : ~pend_v1;
  assign m0_hrdata = (dp_owner == DP_M0) ? s_hrdata : '0;
  assign m1_hrdata = (dp_owner == DP_M1) ? s_hrdata : '0;
  assign m0_hresp  = (dp_owner == DP_M0) ? s_hresp : 1'b0;
  assign m1_hresp  = (dp_owner == DP_M1) ? s_hresp : 1'b0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_v0    <= 1'b0;
      pend_v1    <= 1'b0;
      pend_ap0   <= '0;
      pend_ap1   <= '0;
      dp_owner   <= DP_NONE;
      last_grant <= 1'b1;
      sel_q      <= 1'b0;
      stall_q    <= 1'b0;
    end else begin
      sel_q   <= sel;
      stall_q <= s_vld && !s_hready;
      if (acc)
        last_grant <= sel;
      if (s_hready)
        dp_owner <= acc ? (sel ? DP_M1 : DP_M0) : DP_NONE;

      if (live0 && !(acc && !sel)) begin
        pend_v0  <= 1'b1;
        pend_ap0 <= live_ap0;
      end else if (acc && !sel) begin
        pend_v0 <= 1'b0;
      end

      if (live1 && !(acc && sel)) begin
        pend_v1  <= 1'b1;
        pend_ap1 <= live_ap1;
      end else if (acc && sel) begin
        pend_v1 <= 1'b0;
      end
    end
  end

endmodule
